// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared FSM state type and settle length for the RO PUF measurement path
package ro_puf_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;
    localparam int SETTLE_CYCLES = 3;
endpackage

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: 2-flop synchronizer, previous-sample register and registered rising-edge pulse
//   clk, rst      : system clock, synchronous active-high reset
//   ro_in         : asynchronous oscillator output
//   edge_out      : one-cycle pulse per rising edge of ro_in, 3 cycles after the edge
module ro_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ro_in,
    output logic edge_out
);
    logic s1, s2, prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            prev     <= 1'b0;
            edge_out <= 1'b0;
        end else begin
            s1       <= ro_in;
            s2       <= s1;
            prev     <= s2;
            edge_out <= s2 & ~prev;
        end
    end
endmodule

// File: rtl/ro_pair_counter.sv
// ro_pair_counter: counts rising edges of two ring oscillators over a fixed gate window (RO_SAT_EN selects saturating counters)
//   clk, rst              : system clock, synchronous active-high reset
//   start                 : measurement request, sampled in IDLE only
//   ro_a, ro_b            : asynchronous oscillator outputs
//   busy, done            : measurement in progress / one-cycle result strobe
//   count_a, count_b      : edge counts of the last window
//   response, tie         : count_a > count_b / count_a == count_b
//   overflow              : a counter saturated (RO_SAT_EN builds only)
module ro_pair_counter
    import ro_puf_pkg::*;
#(
    parameter int GATE_CYCLES = 4096,
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b,
    output logic             response,
    output logic             tie,
    output logic             overflow
);
    state_t              state;
    logic [1:0]          sc;
    logic [GATE_W-1:0]   gc;
    logic [CNT_W-1:0]    cnt_a, cnt_b, next_a, next_b;
    logic                edge_a, edge_b, ovf_next;

    ro_edge_sync u_sync_a (.clk(clk), .rst(rst), .ro_in(ro_a), .edge_out(edge_a));
    ro_edge_sync u_sync_b (.clk(clk), .rst(rst), .ro_in(ro_b), .edge_out(edge_b));

`ifdef RO_SAT_EN
    assign next_a   = &cnt_a ? cnt_a : cnt_a + CNT_W'(edge_a);
    assign next_b   = &cnt_b ? cnt_b : cnt_b + CNT_W'(edge_b);
    assign ovf_next = &next_a | &next_b;
`else
    assign next_a   = cnt_a + CNT_W'(edge_a);
    assign next_b   = cnt_b + CNT_W'(edge_b);
    assign ovf_next = 1'b0;
`endif

    assign busy = (state == SETTLE) || (state == GATE);

    // Results are captured on the last GATE edge (including that cycle's edge) so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sc       <= '0;
            gc       <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            done     <= 1'b0;
            count_a  <= '0;
            count_b  <= '0;
            response <= 1'b0;
            tie      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sc <= '0;
                    if (start) state <= SETTLE;
                end
                SETTLE: begin
                    cnt_a <= '0;
                    cnt_b <= '0;
                    gc    <= '0;
                    sc    <= sc + 2'd1;
                    if (sc == 2'(SETTLE_CYCLES - 1)) state <= GATE;
                end
                GATE: begin
                    cnt_a <= next_a;
                    cnt_b <= next_b;
                    gc    <= gc + GATE_W'(1);
                    if (gc == GATE_W'(GATE_CYCLES - 1)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        count_a  <= next_a;
                        count_b  <= next_b;
                        response <= next_a > next_b;
                        tie      <= next_a == next_b;
                        overflow <= ovf_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ro_pair_counter.sv
// tb_ro_pair_counter: scoreboard bench for ro_pair_counter (normal, tie, abort, ignored start, back-to-back, counter limit)
module tb_ro_pair_counter;
    localparam int GC = 400;
    localparam int LGC = 200;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start_l = 1'b0;
    logic        ro_a = 1'b0, ro_b = 1'b0, ro_c = 1'b0;
    logic        busy, done, response, tie, overflow;
    logic [15:0] count_a, count_b;
    logic        busy_l, done_l, resp_l, tie_l, ovf_l;
    logic [3:0]  ca_l, cb_l;

    typedef struct {
        int   a_lo, a_hi, b_lo, b_hi;
        logic resp, tie, ovf;
    } exp_t;
    exp_t sb[$];

    int pass_n = 0, total = 0;
    int cyc = 0, per_a = 8, per_b = 10;
    bit same_b = 1'b0;

    ro_pair_counter #(.GATE_CYCLES(GC), .GATE_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .busy(busy), .done(done), .count_a(count_a), .count_b(count_b),
        .response(response), .tie(tie), .overflow(overflow)
    );

    ro_pair_counter #(.GATE_CYCLES(LGC), .GATE_W(8), .CNT_W(4)) dut_lim (
        .clk(clk), .rst(rst), .start(start_l), .ro_a(ro_c), .ro_b(1'b0),
        .busy(busy_l), .done(done_l), .count_a(ca_l), .count_b(cb_l),
        .response(resp_l), .tie(tie_l), .overflow(ovf_l)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        ro_a = (cyc % per_a) < per_a / 2;
        ro_b = same_b ? ro_a : (cyc % per_b) < per_b / 2;
        ro_c = (cyc % 4) < 2;
    end

    task automatic measure(input bit pulse_mid, output int lat, output int nd);
        lat = -1;
        nd  = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL busy_after_start got %0b want 1", busy);
        else pass_n++;
        for (int k = 1; k <= GC + 20; k++) begin
            if (done === 1'b1) begin
                nd++;
                if (lat < 0) lat = k;
                total++;
                if (busy !== 1'b0) $display("FAIL busy_in_done got %0b want 0", busy);
                else pass_n++;
            end
            if (pulse_mid) start = (k == 50);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        repeat (2) begin
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) $display("FAIL reset_busy_done got %0b%0b want 00", busy, done);
            else pass_n++;
        end
        total++;
        if ({count_a, count_b, response, tie, overflow} !== '0)
            $display("FAIL reset_outputs got %0d/%0d r%0b t%0b o%0b want 0", count_a, count_b, response, tie, overflow);
        else pass_n++;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_normal;
        int lat, nd;
        exp_t e;
        per_a = 8; per_b = 10; same_b = 1'b0;
        sb.push_back('{50, 50, 40, 40, 1'b1, 1'b0, 1'b0});
        measure(1'b0, lat, nd);
        total++;
        if (lat != GC + 4) $display("FAIL normal_latency got %0d want %0d", lat, GC + 4);
        else pass_n++;
        total++;
        if (nd != 1) $display("FAIL normal_done_count got %0d want 1", nd);
        else pass_n++;
        e = sb.pop_front();
        total++;
        if (int'(count_a) < e.a_lo || int'(count_a) > e.a_hi) $display("FAIL normal_count_a got %0d want %0d", count_a, e.a_lo);
        else pass_n++;
        total++;
        if (int'(count_b) < e.b_lo || int'(count_b) > e.b_hi) $display("FAIL normal_count_b got %0d want %0d", count_b, e.b_lo);
        else pass_n++;
        total++;
        if ({response, tie, overflow} !== {e.resp, e.tie, e.ovf})
            $display("FAIL normal_flags got r%0b t%0b o%0b want r%0b t%0b o%0b", response, tie, overflow, e.resp, e.tie, e.ovf);
        else pass_n++;
    endtask

    task automatic test_tie;
        int lat, nd;
        exp_t e;
        per_a = 12; same_b = 1'b1;
        sb.push_back('{33, 34, 33, 34, 1'b0, 1'b1, 1'b0});
        measure(1'b0, lat, nd);
        e = sb.pop_front();
        total++;
        if (nd != 1 || count_a !== count_b) $display("FAIL tie_counts got %0d/%0d done %0d want equal, 1 done", count_a, count_b, nd);
        else pass_n++;
        total++;
        if (int'(count_a) < e.a_lo || int'(count_a) > e.a_hi) $display("FAIL tie_count_a got %0d want %0d..%0d", count_a, e.a_lo, e.a_hi);
        else pass_n++;
        total++;
        if ({response, tie} !== {e.resp, e.tie}) $display("FAIL tie_flags got r%0b t%0b want r%0b t%0b", response, tie, e.resp, e.tie);
        else pass_n++;
        same_b = 1'b0;
    endtask

    task automatic test_abort;
        int lat, nd, early;
        exp_t e;
        per_a = 8; per_b = 10;
        early = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k < 100; k++) begin
            if (done === 1'b1) early++;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        total++;
        if (early != 0 || done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_ctrl got done %0d/%0b busy %0b want 0", early, done, busy);
        else pass_n++;
        total++;
        if ({count_a, count_b, response, tie, overflow} !== '0) $display("FAIL abort_outputs got %0d/%0d r%0b t%0b want 0", count_a, count_b, response, tie);
        else pass_n++;
        sb.push_back('{50, 50, 40, 40, 1'b1, 1'b0, 1'b0});
        measure(1'b0, lat, nd);
        e = sb.pop_front();
        total++;
        if (lat != GC + 4 || int'(count_a) != e.a_lo || int'(count_b) != e.b_lo || response !== e.resp)
            $display("FAIL abort_restart got lat %0d %0d/%0d r%0b want %0d %0d/%0d r%0b", lat, count_a, count_b, response, GC + 4, e.a_lo, e.b_lo, e.resp);
        else pass_n++;
    endtask

    task automatic test_ignored_start;
        int lat, nd;
        measure(1'b1, lat, nd);
        total++;
        if (nd != 1 || lat != GC + 4) $display("FAIL ignored_start got %0d done at %0d want 1 at %0d", nd, lat, GC + 4);
        else pass_n++;
    endtask

    task automatic test_back_to_back;
        int seen;
        exp_t e;
        sb.push_back('{50, 50, 40, 40, 1'b1, 1'b0, 1'b0});
        sb.push_back('{50, 50, 40, 40, 1'b1, 1'b0, 1'b0});
        @(negedge clk) start = 1'b1;
        for (int m = 0; m < 2; m++) begin
            seen = 0;
            for (int k = 0; k < GC + 20 && seen == 0; k++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) seen = 1;
            end
            total++;
            if (seen == 0) $display("FAIL b2b_done_%0d got none want 1", m);
            else pass_n++;
            e = sb.pop_front();
            total++;
            if (int'(count_a) != e.a_lo || int'(count_b) != e.b_lo) $display("FAIL b2b_counts_%0d got %0d/%0d want %0d/%0d", m, count_a, count_b, e.a_lo, e.b_lo);
            else pass_n++;
            if (m == 0) begin
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                total++;
                if (busy !== 1'b1) $display("FAIL b2b_restart got busy %0b want 1", busy);
                else pass_n++;
                start = 1'b0;
            end
        end
    endtask

    task automatic test_counter_limit;
        int seen;
        exp_t e;
`ifdef RO_SAT_EN
        sb.push_back('{15, 15, 0, 0, 1'b1, 1'b0, 1'b1});
`else
        sb.push_back('{2, 2, 0, 0, 1'b1, 1'b0, 1'b0});
`endif
        @(negedge clk) start_l = 1'b1;
        @(posedge clk);
        #1 start_l = 1'b0;
        seen = 0;
        for (int k = 1; k <= LGC + 20 && seen == 0; k++) begin
            if (done_l === 1'b1) seen = k;
            else begin
                @(posedge clk);
                #1;
            end
        end
        total++;
        if (seen != LGC + 4) $display("FAIL limit_latency got %0d want %0d", seen, LGC + 4);
        else pass_n++;
        e = sb.pop_front();
        total++;
        if (int'(ca_l) != e.a_lo || int'(cb_l) != e.b_lo) $display("FAIL limit_counts got %0d/%0d want %0d/%0d", ca_l, cb_l, e.a_lo, e.b_lo);
        else pass_n++;
        total++;
        if ({resp_l, tie_l, ovf_l} !== {e.resp, e.tie, e.ovf})
            $display("FAIL limit_flags got r%0b t%0b o%0b want r%0b t%0b o%0b", resp_l, tie_l, ovf_l, e.resp, e.tie, e.ovf);
        else pass_n++;
    endtask

    initial begin
        test_reset;
        test_normal;
        test_tie;
        test_abort;
        test_ignored_start;
        test_back_to_back;
        test_counter_limit;
        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end
endmodule

// File: doc/ro_pair_counter.md
# ro_pair_counter

Measurement end of the ring-oscillator PUF. It samples two free-running ring-oscillator outputs and counts their rising edges over an identical gate window of system-clock cycles. It then returns both counts and the one-bit PUF response, which is 1 when oscillator A counted more edges than oscillator B. The block sits between a pair of oscillator instances and the challenge/response controller.

## Interface
- GATE_CYCLES, 4096: length of the counting window in clk cycles (≥1).
- GATE_W, 16: width of the gate-window counter; 2^GATE_W must exceed GATE_CYCLES.
- CNT_W, 16: width of each edge counter and of each count output.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a measurement; sampled only in IDLE.
- ro_a  input  1  oscillator A output, asynchronous to clk.
- ro_b  input  1  oscillator B output, asynchronous to clk.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the results update.
- count_a  output  CNT_W  edges of ro_a in the last window.
- count_b  output  CNT_W  edges of ro_b in the last window.
- response  output  1  1 when count_a > count_b, else 0.
- tie  output  1  1 when count_a == count_b.
- overflow  output  1  1 when either counter saturated (only meaningful with RO_SAT_EN).

## Operation
- ro_a and ro_b each pass through a 2-flop synchronizer followed by a previous-sample register. A rising edge is current==1 && previous==0.
- The connected oscillator frequency must be below clk/2; this is a system requirement, not checked in RTL.
- FSM states:
  - IDLE: busy=0. start=1 moves to SETTLE.
  - SETTLE: lasts 3 cycles; clears the edge and gate counters so that stale synchronizer contents are never counted.
  - GATE: lasts GATE_CYCLES cycles; increments count_a or count_b on each detected edge.
  - DONE: lasts 1 cycle; registers the outputs, pulses done, returns to IDLE.
- response and tie are computed from the final counts and registered in DONE together with count_a, count_b and overflow.
- Outputs hold their values until the next DONE.
- start is ignored in SETTLE, GATE and DONE. There is no queueing.
- Counter width rule: without RO_SAT_EN, the edge counters wrap modulo 2^CNT_W.
- rst at any point: FSM goes to IDLE, all counters and synchronizer flops clear, no done pulse is issued.

## Timing
- Reset values: busy=0, done=0, count_a=0, count_b=0, response=0, tie=0, overflow=0.
- start high at clock edge T0 (in IDLE):
  - busy=1 at T0+1.
  - SETTLE covers T0+1..T0+3.
  - GATE covers T0+4..T0+3+GATE_CYCLES.
  - done=1 and new outputs are valid at T0+4+GATE_CYCLES. busy=0 in that same cycle.
- Edge-to-count latency is 3 cycles (2 sync flops plus the detect register). Edges are attributed by their detect cycle falling inside GATE.
- start held high continuously starts a new measurement on the cycle after done, since that cycle is IDLE.
- rst wins over start in the same cycle.

## Configuration
- RO_SAT_EN defined:
  - Edge counters stop at all-ones instead of wrapping.
  - overflow is registered in DONE as the OR of both counters being at all-ones.
- RO_SAT_EN undefined:
  - Edge counters wrap.
  - overflow is tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package ro_puf_pkg holds:
  - the FSM state enum (IDLE, SETTLE, GATE, DONE);
  - the constant SETTLE_CYCLES = 3.
- Sub-module ro_edge_sync contains the 2-flop synchronizer, the previous-sample register and the rising-edge pulse. It has ports clk, rst, ro_in, edge_out. It is instantiated twice, once for ro_a and once for ro_b.

## Test plan
- Reset check: assert rst for 2 cycles with both oscillators toggling -> all outputs 0, no done.
- Normal measurement: GATE_CYCLES=400, ro_a period 8 clk, ro_b period 10 clk -> done at T0+404; count_a=50±1, count_b=40±1; response=1, tie=0.
- Tie: both oscillators driven by the same period-12 waveform -> count_a==count_b, tie=1, response=0.
- Abort: rst asserted at T0+100 during GATE -> no done pulse; busy=0 next cycle; outputs 0. A following start completes normally.
- Ignored start: start pulsed during GATE -> exactly one done, at T0+4+GATE_CYCLES.
- Counter limit: CNT_W=4, GATE_CYCLES=200, ro_a period 4 (50 edges):
  - with RO_SAT_EN: count_a=15, overflow=1;
  - without RO_SAT_EN: count_a=50 mod 16=2, overflow=0.
